uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel UART receive path: 8N1 framing, LSB first, idle-high line. Sits inside computer beside the existing transmit path, fed from the top-level uart_rx pin. Delivers each received byte to the CPU I/O logic through a one-entry holding register with a valid/ready handshake. Reports framing errors and overruns.

Parameters:
CLOCK_FREQ, 20_000_000, system clock frequency in Hz (PLL output).
BAUD_RATE, 115200, line bit rate.
CLKS_PER_BIT, derived localparam = CLOCK_FREQ/BAUD_RATE (integer division, 173 at defaults); not overridable.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
uart_rx  input  1  asynchronous serial line; idle = 1
rx_data_o  output  8  received byte; held stable while rx_valid_o = 1
rx_valid_o  output  1  holding register contains an unread byte
rx_ready_i  input  1  consumer accepts the byte (pop when rx_valid_o & rx_ready_i)
frame_error_o  output  1  sticky; set when a stop bit is sampled low
overrun_o  output  1  sticky; set when a completed byte is dropped because the holding register was full
clear_errors_i  input  1  one-cycle pulse; clears both sticky flags

Behaviour:
- Reset values: rx_data_o = 8'h00, rx_valid_o = 0, frame_error_o = 0, overrun_o = 0. The FSM enters IDLE, counters are 0, and both synchronizer flops are 1. Reset mid-frame abandons the frame with no output change beyond the reset values.
- Synchronizer: uart_rx passes through 2 flops. All decisions use the second flop (rx_s), so there are 2 cycles of input latency.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is reloaded to 0 on every state change.
- IDLE: stay while rx_s = 1. On rx_s = 0, go to START with the counter at 0.
- START: at count = CLKS_PER_BIT/2 - 1 (mid start bit, 85 at defaults), resample. If rx_s = 0, go to DATA with bit index = 0 and counter = 0. If rx_s = 1, treat it as a glitch and return to IDLE with no flags set.
- DATA: at count = CLKS_PER_BIT-1 (mid-bit), shift rx_s into shift_reg[7] with a right shift, so bit 0 lands in shift_reg[0] after 8 samples. Increment the bit index. After the 8th sample, go to STOP.
- STOP: at count = CLKS_PER_BIT-1, sample the stop bit.
  - rx_s = 1: byte complete. Evaluate the delivery rule below, then return to IDLE.
  - rx_s = 0: set frame_error_o, discard the byte (holding register untouched), go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Delivery rule, evaluated in the cycle the stop bit is accepted:
  - If rx_valid_o = 0, or rx_ready_i = 1 in that same cycle, load rx_data_o with shift_reg and set rx_valid_o = 1. Simultaneous pop and load is allowed; the new byte wins and no overrun is flagged.
  - Otherwise keep the old byte and set overrun_o.
- rx_valid_o clears in the cycle after rx_valid_o & rx_ready_i, unless a load happens in that same cycle.
- Sticky flags: clear_errors_i clears both. If a set event and clear_errors_i occur in the same cycle, set wins.
- Latency: rx_valid_o rises 1 cycle after the mid-stop-bit sample, about 9.5 bit times plus 3 cycles after the line's falling edge.
- Back-to-back frames: a start bit immediately after the stop-bit sample is detected without loss, because IDLE is re-entered mid-stop-bit.

Decomposition:
- Shared package (uart_pkg): the FSM state enum (IDLE, START, DATA, STOP, BREAK_WAIT) and the 8N1 constants DATA_BITS = 8 and STOP_BITS = 1. These are shared with the existing UART transmitter.
- One natural sub-module: sync_2ff, a 2-flop synchronizer with a reset value parameter (1 here). It is reusable for other asynchronous inputs such as buttons.
- The baud counter stays inline.

Test Plan:
1. Reset, then line held at 1 for 2000 cycles -> rx_valid_o = 0, rx_data_o = 8'h00, both flags = 0.
2. Drive 0x55 as an 8N1 frame at 173 cycles/bit with rx_ready_i = 0 -> rx_valid_o = 1, rx_data_o = 8'h55, frame_error_o = 0. Then pulse rx_ready_i for 1 cycle -> rx_valid_o = 0 the next cycle.
3. Drive 0xA3, then 0x0F back-to-back with rx_ready_i = 0 -> rx_data_o stays 8'hA3 and overrun_o = 1. Repeat with rx_ready_i asserted on the 0x0F load cycle -> rx_data_o = 8'h0F and overrun_o = 0.
4. Drive a frame of 0xC3 with the stop bit forced to 0, then the line low for 3 bit times, then 0x3C -> frame_error_o = 1 and no valid for 0xC3. The next valid carries 8'h3C. Pulse clear_errors_i -> frame_error_o = 0.
5. Drive a 40-cycle low glitch on an idle line -> FSM returns to IDLE, no rx_valid_o, no flags. A following 0x81 frame is received correctly.
6. Assert reset for 1 cycle mid-DATA of a 0xFF frame, then send 0x12 -> no byte delivered from the aborted frame, all outputs at reset values, and 0x12 is received correctly afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   - uart_state_e : receiver/transmitter framing FSM states
//   - DATA_BITS    : payload bits per frame (8N1)
//   - STOP_BITS    : stop bits per frame (8N1)
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   reset : synchronous, active-high; both flops load RESET_VALUE
//   d     : asynchronous input
//   q     : synchronized output (2 cycles of latency)
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path, LSB first, idle-high line.
//   clk            : system clock
//   reset          : synchronous, active-high
//   uart_rx        : asynchronous serial input
//   rx_data_o      : received byte, stable while rx_valid_o = 1
//   rx_valid_o     : holding register holds an unread byte
//   rx_ready_i     : consumer pops the byte when rx_valid_o & rx_ready_i
//   frame_error_o  : sticky, stop bit sampled low
//   overrun_o      : sticky, completed byte dropped (holding register full)
//   clear_errors_i : one-cycle pulse clearing both sticky flags
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 20_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_error_o,
    output logic                 overrun_o,
    input  logic                 clear_errors_i
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS);

    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    logic baud_done, half_done;
    logic stop_accept, stop_fail, load, pop;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (uart_rx),
        .q     (rx_s)
    );

    assign baud_done   = (baud_cnt == FULL_LAST);
    assign half_done   = (baud_cnt == HALF_LAST);
    assign stop_accept = (state == STOP) && baud_done && rx_s;
    assign stop_fail   = (state == STOP) && baud_done && !rx_s;
    assign pop         = rx_valid_o && rx_ready_i;
    // A pop in the same cycle frees the holding register for the new byte.
    assign load        = stop_accept && (!rx_valid_o || rx_ready_i);

    // Framing FSM. The baud counter restarts at 0 on every state change
    // and at every sampled data bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (half_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        // Line back high at mid start bit: a glitch, not a frame.
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Returning to IDLE mid-stop-bit lets a back-to-back
                        // start bit be caught on time.
                        state    <= rx_s ? IDLE : BREAK_WAIT;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    baud_cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: begin
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Holding register and sticky flags; set beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            frame_error_o <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            if (load) begin
                rx_data_o  <= shift_reg;
                rx_valid_o <= 1'b1;
            end else if (pop) begin
                rx_valid_o <= 1'b0;
            end

            if (stop_fail)           frame_error_o <= 1'b1;
            else if (clear_errors_i) frame_error_o <= 1'b0;

            if (stop_accept && !load) overrun_o <= 1'b1;
            else if (clear_errors_i)  overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int CPB    = 20_000_000 / 115200;
    localparam int FRAME  = 10 * CPB;
    // Drive-cycle index whose following edge samples the stop bit:
    // 2 sync flops + 1 idle edge, half a bit to mid-start, 9 whole bits.
    localparam int LOAD_C = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset, uart_rx, rx_ready_i, clear_errors_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, frame_error_o, overrun_o;

    always #5 clk = ~clk;

    uart_receiver dut (
        .clk            (clk),
        .reset          (reset),
        .uart_rx        (uart_rx),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_ready_i     (rx_ready_i),
        .frame_error_o  (frame_error_o),
        .overrun_o      (overrun_o),
        .clear_errors_i (clear_errors_i)
    );

    int checks   = 0;
    int failures = 0;

    // Frame-level reference model of the holding register and flags.
    logic [7:0] m_data;
    logic       m_valid, m_ferr, m_ovr;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},  rx_data_o,     m_data);
        chk({tag, ".valid"}, rx_valid_o,    m_valid);
        chk({tag, ".ferr"},  frame_error_o, m_ferr);
        chk({tag, ".ovr"},   overrun_o,     m_ovr);
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            uart_rx = 1'b1;
        end
    endtask

    // Drive one 8N1 frame. pop_at / rst_at: drive-cycle index for a one-cycle
    // rx_ready_i / reset pulse, or -1 for none.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int pop_at, input int rst_at);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            uart_rx    = bits[c / CPB];
            rx_ready_i = (c == pop_at);
            reset      = (c == rst_at);
        end
        if (rst_at >= 0) begin
            model_reset();
        end else if (stop) begin
            if (!m_valid || pop_at >= 0) begin
                m_data  = b;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            m_ferr = 1'b1;
            if (pop_at >= 0) m_valid = 1'b0;
        end
    endtask

    task automatic pop_pulse();
        @(negedge clk); rx_ready_i = 1'b1;
        @(negedge clk); rx_ready_i = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        @(negedge clk); clear_errors_i = 1'b1;
        @(negedge clk); clear_errors_i = 1'b0;
        m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        int         mode, pat;

        // 1: reset and long idle
        reset = 1'b1; uart_rx = 1'b1; rx_ready_i = 1'b0; clear_errors_i = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        idle(2000);
        check_all("reset_idle");

        // 2: single byte, then a one-cycle pop
        send_frame(8'h55, 1'b1, -1, -1);
        idle(20);
        check_all("rx_55");
        pop_pulse();
        check_all("pop_55");

        // 3: overrun, then simultaneous pop and load
        send_frame(8'hA3, 1'b1, -1, -1);
        send_frame(8'h0F, 1'b1, -1, -1);
        idle(20);
        check_all("overrun");
        clear_pulse();
        pop_pulse();
        send_frame(8'hA3, 1'b1, -1, -1);
        send_frame(8'h0F, 1'b1, LOAD_C, -1);
        idle(20);
        check_all("pop_load");
        pop_pulse();

        // 4: framing error, held-low line, recovery
        send_frame(8'hC3, 1'b0, -1, -1);
        repeat (3 * CPB) @(negedge clk);
        check_all("frame_err");
        idle(20);
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(20);
        check_all("after_break");
        clear_pulse();
        check_all("clear_ferr");
        pop_pulse();

        // 5: short glitch rejected, next frame fine
        repeat (40) begin
            @(negedge clk);
            uart_rx = 1'b0;
        end
        idle(400);
        check_all("glitch");
        send_frame(8'h81, 1'b1, -1, -1);
        idle(20);
        check_all("rx_81");

        // 6: reset mid-DATA abandons the frame
        send_frame(8'hFF, 1'b1, -1, 4 * CPB + 60);
        idle(20);
        check_all("reset_mid");
        send_frame(8'h12, 1'b1, -1, -1);
        idle(20);
        check_all("rx_12");

        // Randomized frames against the model
        for (int i = 0; i < 16; i++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            mode  = $urandom_range(0, 2);
            pat   = (mode == 1) ? LOAD_C :
                    (mode == 2) ? $urandom_range(10, LOAD_C - 10) : -1;
            send_frame(rb, rstop, pat, -1);
            if (!rstop) idle(20);
            else        idle($urandom_range(0, 40));
            check_all($sformatf("rand%0d", i));
            if ($urandom_range(0, 3) == 0) begin
                clear_pulse();
                check_all($sformatf("rand_clr%0d", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
